// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a show-ahead byte FIFO and sticky frame/overflow flags.
// Bit timing comes from a fixed CLK_DIV; dbg_state exposes the receive FSM state.
module uart_rx_fifo #(
    parameter int CLK_DIV    = 106,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        frame_err,
    output logic                        overflow,
    input  logic                        clr_err,
    output logic [2:0]                  dbg_state
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLK_DIV / 2 - 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t          r_state;
    logic [1:0]      r_sync;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_sh;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [AW:0]     r_level;
    logic            r_frame_err;
    logic            r_overflow;

    logic w_rx_s;
    logic w_bit_end;
    logic w_stop_samp;
    logic w_push;
    logic w_frame_evt;
    logic w_pop;
    logic w_push_ok;
    logic w_drop;

    assign w_rx_s      = r_sync[1];
    assign w_bit_end   = (r_cnt == LAST_CNT);
    assign w_stop_samp = (r_state == S_STOP) && w_bit_end;
    assign w_push      = w_stop_samp && w_rx_s;
    assign w_frame_evt = w_stop_samp && !w_rx_s;
    assign w_pop       = rx_valid && rx_ready;
    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    assign w_push_ok   = w_push && ((r_level != FULL_LVL) || w_pop);
    assign w_drop      = w_push && !w_push_ok;

    assign rx_valid  = (r_level != '0);
    assign rx_data   = r_mem[r_rp];
    assign level     = r_level;
    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
        end else begin
            r_sync <= {r_sync[0], rx};
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == HALF_CNT) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        r_sh  <= {w_rx_s, r_sh[7:1]};
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop-bit leaves half a bit of slack for the next start edge.
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wp] <= r_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_level     <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
            // A new error event outranks a clear in the same cycle.
            if (w_frame_evt) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Synthesizable 8N1 UART receiver with a small show-ahead byte FIFO. Sits directly downstream of the SoC `ser_tx` line (or any serial pin) and converts the bit stream into bytes with a valid/ready handshake. Used as on-chip loopback/capture logic and as the hardware counterpart of the bench serial monitor. Bit timing is a fixed integer clock divider; no baud-rate register.

## Interface

- `CLK_DIV`, 106: clock cycles per bit; minimum 4; half-bit point = `CLK_DIV/2` (integer floor).
- `FIFO_DEPTH`, 8: byte entries; power of two, 2..64.
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  8  byte at FIFO head; valid only while `rx_valid`=1.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts head byte when `rx_valid && rx_ready` (pop).
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `frame_err`  out  1  sticky: a stop bit sampled low.
- `overflow`  out  1  sticky: a complete byte was dropped because FIFO full.
- `clr_err`  in  1  single-cycle pulse clears both sticky flags.

## Operation

- Input: `rx` passes a 2-flop synchronizer (both flops reset to 1); all decisions use the second flop, `rx_s`.
- FSM states IDLE, START, DATA, STOP, WAIT_HIGH; one bit counter (0..CLK_DIV-1), one bit index (0..7), 8-bit shift register.
- IDLE: `rx_s`=0 -> START, bit counter cleared.
- START: at count `CLK_DIV/2 - 1` sample `rx_s`; 0 -> DATA (counter cleared); 1 -> IDLE (glitch rejected, nothing reported).
- DATA: at count `CLK_DIV-1` shift `rx_s` in LSB-first (`{rx_s, sh[7:1]}`); after 8th bit -> STOP.
- STOP: at count `CLK_DIV-1` sample `rx_s`; 1 -> push shift register into FIFO, -> IDLE; 0 -> set `frame_err`, discard byte, -> WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then IDLE (break condition produces exactly one error, no bytes).
- FIFO: circular buffer, read/write pointers wrap modulo `FIFO_DEPTH`; `rx_data` = entry at read pointer (show-ahead, no read latency).
- Push accepted if `level < FIFO_DEPTH`, or if a pop occurs in the same cycle; otherwise byte dropped and `overflow` set.
- Simultaneous push+pop: `level` unchanged, both pointers advance.
- Pop when empty ignored; `rx_ready` has no effect while `rx_valid`=0.
- `clr_err` in same cycle as a new error event: set wins (flag stays 1).

## Timing

- Reset values: `rx_valid`=0, `level`=0, `frame_err`=0, `overflow`=0, `rx_data` don't-care (register contents, not required zero), FSM=IDLE, pointers=0.
- Reset mid-frame: partial byte discarded, FIFO emptied, flags cleared, next falling edge after reset starts a fresh frame.
- Let T0 = first cycle `rx_s`=0 in IDLE. Start check at T0+`CLK_DIV/2`; data bit k sampled at T0+`CLK_DIV/2`+(k+1)·`CLK_DIV`; stop at T0+`CLK_DIV/2`+9·`CLK_DIV` (=T0+1007 for default).
- `rx_valid`/`level` update the cycle after the stop sample; `frame_err`/`overflow` likewise.
- `rx` to `rx_s` latency: 2 cycles.
- Back-to-back frames: FSM reaches IDLE at stop sample (mid-stop-bit), so next start edge is detected with no lost frame at nominal rate; tolerates ±4% baud mismatch.
- Pop is combinational on handshake; next head byte visible the cycle after pop.

## Test plan

- Single byte 0x55, `CLK_DIV`=106, `rx_ready`=0 -> `rx_valid`=1 at T0+1008, `rx_data`=0x55, `level`=1, flags 0; then `rx_ready` pulse -> `rx_valid`=0, `level`=0.
- Back-to-back 0x00, 0xFF, 0xA5 with `rx_ready`=1 -> consumer receives exactly 0x00, 0xFF, 0xA5 in order, `level` never exceeds 1.
- 30-cycle low glitch on idle `rx` -> no byte, no flag, FSM back in IDLE.
- Frame 0x3C with stop bit held low for 3 bit times -> `frame_err`=1, `level`=0; next valid frame 0x12 received normally; `clr_err` -> `frame_err`=0.
- 9 bytes 0x01..0x09 with `rx_ready`=0, `FIFO_DEPTH`=8 -> `level`=8, `overflow`=1, pops return 0x01..0x08 (wrap-around exercised by a further 4 bytes after draining).
- Assert `reset` during data bit 4 of 0x77 -> all outputs at reset values next cycle; subsequent 0x42 received correctly.
